// File: rtl/chipper_local_nic.sv
// Local-port endpoint for a CHIPPER router node: formats core payloads into flits for
// injection on lin, and buffers/checks flits ejected on lout for the core.
module chipper_local_nic #(
   parameter logic [3:0] NODE_ID  = 4'd0,
   parameter int         TX_DEPTH = 4,
   parameter int         RX_DEPTH = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_tx_valid,
   input  logic [3:0] i_tx_dest,
   input  logic [4:0] i_tx_data,
   output logic       o_tx_ready,
   output logic [9:0] o_lin,
   input  logic       i_inj_free,
   input  logic [9:0] i_lout,
   output logic       o_rx_valid,
   input  logic       i_rx_ready,
   output logic [4:0] o_rx_data,
   output logic       o_rx_src_ok,
   output logic [7:0] o_drop_cnt,
   output logic [7:0] o_misroute_cnt,
   output logic       o_ovf
);
   localparam int TAW = $clog2(TX_DEPTH);
   localparam int RAW = $clog2(RX_DEPTH);

   // ---------------- injection path ----------------
   logic [8:0]   r_tx_mem [TX_DEPTH];
   logic [TAW:0] r_tx_wp, r_tx_rp;
   logic         w_tx_empty, w_tx_full, w_tx_pop, w_tx_push;

   assign w_tx_empty = (r_tx_wp == r_tx_rp);
   assign w_tx_full  = (r_tx_wp[TAW-1:0] == r_tx_rp[TAW-1:0]) && (r_tx_wp[TAW] != r_tx_rp[TAW]);
   assign w_tx_pop   = i_inj_free && !w_tx_empty;
   // A pop on the same edge frees the slot, so a full FIFO still absorbs the push.
   assign w_tx_push  = i_tx_valid && (!w_tx_full || w_tx_pop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tx_wp <= '0;
         r_tx_rp <= '0;
      end else begin
         if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
         if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wp[TAW-1:0]] <= {i_tx_dest, i_tx_data};
   end

   // Decoded purely from registered state, so lin is stable for the whole cycle.
   assign o_tx_ready = !w_tx_full;
   assign o_lin      = w_tx_empty ? 10'b0 : {1'b1, r_tx_mem[r_tx_rp[TAW-1:0]]};

   // ---------------- ejection path ----------------
   logic [5:0]   r_rx_mem [RX_DEPTH];
   logic [RAW:0] r_rx_wp, r_rx_rp;
   logic         w_rx_empty, w_rx_full, w_rx_pop, w_rx_push, w_rx_drop, w_lout_vld, w_dest_ok;
   logic [7:0]   r_drop_cnt, r_mis_cnt;
   logic         r_ovf;

   assign w_lout_vld = i_lout[9];
   assign w_dest_ok  = (i_lout[8:5] == NODE_ID);
   assign w_rx_empty = (r_rx_wp == r_rx_rp);
   assign w_rx_full  = (r_rx_wp[RAW-1:0] == r_rx_rp[RAW-1:0]) && (r_rx_wp[RAW] != r_rx_rp[RAW]);
   assign w_rx_pop   = !w_rx_empty && i_rx_ready;
   assign w_rx_push  = w_lout_vld && (!w_rx_full || w_rx_pop);
   assign w_rx_drop  = w_lout_vld && w_rx_full && !w_rx_pop;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rx_wp    <= '0;
         r_rx_rp    <= '0;
         r_drop_cnt <= '0;
         r_mis_cnt  <= '0;
         r_ovf      <= 1'b0;
      end else begin
         if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
         if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
         if (w_rx_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
         if (w_rx_drop) r_ovf <= 1'b1;
         if (w_lout_vld && !w_dest_ok && r_mis_cnt != 8'hFF) r_mis_cnt <= r_mis_cnt + 8'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_rx_push) r_rx_mem[r_rx_wp[RAW-1:0]] <= {w_dest_ok, i_lout[4:0]};
   end

   assign o_rx_valid     = !w_rx_empty;
   assign o_rx_data      = w_rx_empty ? 5'd0 : r_rx_mem[r_rx_rp[RAW-1:0]][4:0];
   assign o_rx_src_ok    = w_rx_empty ? 1'b0 : r_rx_mem[r_rx_rp[RAW-1:0]][5];
   assign o_drop_cnt     = r_drop_cnt;
   assign o_misroute_cnt = r_mis_cnt;
   assign o_ovf          = r_ovf;
endmodule

// File: doc/chipper_local_nic.md
Name: chipper_local_nic

Overview:
- Node-side endpoint of the CHIPPER router's local port: the block the router's local injection and ejection path talk to.
- Accepts payloads from the core, formats them as 10-bit flits, queues them, and drives the router's local input `lin`.
- Captures flits ejected on the router's local output `lout`, checks them, buffers them, and hands them to the core over a valid/ready interface.
- Instantiated once per node, beside the chipper router.

Parameters:
- NODE_ID, 0, 4-bit address of this node; ejected flits are checked against it.
- TX_DEPTH, 4, injection FIFO depth; power of 2, ≥2.
- RX_DEPTH, 4, ejection FIFO depth; power of 2, ≥2.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- tx_valid  in  1  core offers a flit.
- tx_dest  in  4  destination node.
- tx_data  in  5  payload.
- tx_ready  out  1  injection FIFO not full.
- lin  out  10  flit to router local input.
- inj_free  in  1  router has a free output slot this cycle; when high, the router consumes a valid `lin` flit.
- lout  in  10  flit ejected by router.
- rx_valid  out  1  ejection FIFO head valid.
- rx_ready  in  1  core accepts head.
- rx_data  out  5  head payload.
- rx_src_ok  out  1  head's dest field matched NODE_ID.
- drop_cnt  out  8  saturating count of ejected flits lost because the RX FIFO was full.
- misroute_cnt  out  8  saturating count of ejected flits whose dest ≠ NODE_ID.
- ovf  out  1  sticky; set on the first drop.

Behaviour:
- Flit format: [9] valid, [8:5] dest, [4:0] data. A flit with bit9 = 0 is an empty slot.
- Reset (async assert, sync release) clears both FIFOs, both counters and `ovf`. Output values in reset:
  - `lin` = 10'b0; `tx_ready` = 1.
  - `rx_valid` = 0; `rx_data` = 0; `rx_src_ok` = 0.
  - `drop_cnt` = 0; `misroute_cnt` = 0; `ovf` = 0.
- TX push: on a clk edge with `tx_valid` & `tx_ready`, write {dest, data} to the TX FIFO tail. `tx_ready` = !tx_full, registered-count based; no combinational path from `inj_free`.
- `lin` drive:
  - `lin` = {1'b1, head} when the TX FIFO is non-empty, else 10'b0.
  - `lin` is a registered head-occupancy decode; it is stable across the cycle.
- TX pop:
  - On the edge where `inj_free` = 1 and the TX FIFO is non-empty, pop the head. The next entry appears on `lin` one cycle later, so back-to-back injection is 1 flit/cycle.
  - With `inj_free` = 0 the head is held unchanged indefinitely.
- TX simultaneous push and pop while full: allowed; occupancy is unchanged and `tx_ready` stays 0 for that cycle (it is based on the pre-edge count).
- TX simultaneous push and pop while empty: the pop is not performed and the push lands; `lin` shows the flit next cycle.
- Ejection, every edge with `lout[9]` = 1:
  - If `lout[8:5]` ≠ NODE_ID, increment `misroute_cnt`, saturating at 255.
  - The flit is still stored if space exists. Its `rx_src_ok` bit = (dest == NODE_ID), kept per entry.
- RX full:
  - The ejector cannot be back-pressured (bufferless router), so a flit arriving when the RX FIFO is full and no pop happens this edge is discarded.
  - On a discard, `drop_cnt` increments (saturating at 255) and `ovf` is set. `ovf` clears only on reset.
- RX full with simultaneous pop: if `rx_valid` & `rx_ready` on the same edge as the arrival, the pop frees a slot and the flit is stored, not dropped.
- RX output:
  - `rx_valid` = !rx_empty; `rx_data` and `rx_src_ok` come from the FIFO head (registered storage read).
  - Pop occurs on `rx_valid` & `rx_ready`.
- Latency:
  - Core push to `lin` valid: 1 cycle when the TX FIFO is empty.
  - `lout` arrival to `rx_valid`: 1 cycle when the RX FIFO is empty.
- Pointers: log2(depth) bits plus a wrap bit; full when the indices are equal and the wrap bits differ. Pointers wrap modulo depth.
- Counters: 8-bit, hold at 8'hFF, never wrap.
- Reset asserted mid-operation: all queued flits are lost; `lin` goes to 0 immediately (async).

Test Plan:
1. Reset, then push dest=3 data=5'h15 with `inj_free` = 1 → next cycle `lin` = 10'b1_0011_10101; the following cycle `lin` = 0.
2. `inj_free` = 0, push 4 flits (TX_DEPTH = 4) → `tx_ready` = 0 after the 4th; raise `inj_free` → `lin` streams the 4 flits on consecutive cycles in FIFO order, then 0.
3. NODE_ID = 2; drive `lout` = {1, 4'd2, 5'h0A} with `rx_ready` = 0 → `rx_valid` = 1, `rx_data` = 5'h0A, `rx_src_ok` = 1, `misroute_cnt` = 0.
4. Hold `rx_ready` = 0 and eject 6 valid flits → 4 stored; `drop_cnt` = 2; `ovf` = 1; draining yields the first 4 in order.
5. RX full; on one edge present a new `lout` flit with `rx_ready` = 1 → no drop, `drop_cnt` unchanged, new flit is last out.
6. Eject 300 flits with dest ≠ NODE_ID → `misroute_cnt` saturates at 8'hFF; assert `rst_n` = 0 mid-stream → all outputs at reset values asynchronously.
